// File: rtl/lcd12864_bus_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lcd12864_pkg
// Description : Shared types and ST7920 constants for the LCD12864 read-side
//               controller (state encoding, status-byte fields, RS codes).
// Revision    : 1.0 - initial release
// ============================================================================
package lcd12864_pkg;

    // Read controller sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        EN_LO = 3'd3,
        CHECK = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Status byte layout: D7 is the busy flag, D6..D0 the address counter
    localparam int         ST7920_BF_BIT  = 7;
    localparam logic [6:0] ST7920_AC_MASK = 7'h7F;

    // RS pin encoding for reads
    localparam logic RS_STATUS = 1'b0;
    localparam logic RS_DATA   = 1'b1;

    // Busy flag of a sampled status byte
    function automatic logic st7920_busy(input logic [7:0] status);
        return status[ST7920_BF_BIT];
    endfunction

    // Address counter field of a sampled status byte
    function automatic logic [6:0] st7920_ac(input logic [7:0] status);
        return status[6:0] & ST7920_AC_MASK;
    endfunction

endpackage : lcd12864_pkg
`default_nettype wire

// File: rtl/lcd12864_bus_reader_if.sv
`default_nettype none
// ============================================================================
// Interface   : lcd12864_bus_reader_if
// Description : Host request/response handshake plus LCD12864 parallel-bus
//               pins. The slave modport is the reader controller, the master
//               modport is the host logic / pin model facing it.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd12864_bus_reader_if;

    // Host request channel
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_poll;

    // Host response channel
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;

    // LCD pins (data bus as seen through the top-level input buffer)
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat;

    modport slave (
        input  req_valid,
        input  req_rs,
        input  req_poll,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_timeout,
        output lcd_rs,
        output lcd_rw,
        output lcd_en,
        input  lcd_dat
    );

    modport master (
        output req_valid,
        output req_rs,
        output req_poll,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_timeout,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_en,
        output lcd_dat
    );

endinterface : lcd12864_bus_reader_if
`default_nettype wire

// File: rtl/lcd12864_bus_reader_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_timer
// Description : Loadable 8-bit down-counter timing the address-setup, E-high
//               and E-low bus phases. Loading N-1 on a phase entry makes done
//               assert on the N-th (last) cycle of that phase.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_timer (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       load,
    input  wire logic [7:0] load_val,
    output logic            done
);

    logic [7:0] r_cnt;

    // Count down to zero and park there until the next load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign done = (r_cnt == 8'd0);

endmodule : lcd_bus_timer
`default_nettype wire

// File: rtl/lcd12864_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : lcd12864_bus_reader
// Description : Read-side controller for the ST7920 LCD12864 8-bit parallel
//               bus. Performs status reads (optionally polled until BF=0) and
//               data reads with E timing derived from the 50 MHz clock.
//               Build option: LCD12864_DUMMY_READ_EN - when defined, every
//               non-poll data read runs two bus cycles and drops the first
//               (stale) sample.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd12864_bus_reader
    import lcd12864_pkg::*;
#(
    parameter int T_AS     = 4,
    parameter int T_PWEH   = 25,
    parameter int T_PWEL   = 35,
    parameter int MAX_POLL = 255
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    lcd12864_bus_reader_if.slave  bus
);

    // Timer reload values: a phase of N cycles is loaded with N-1
    localparam logic [7:0] c_AS_LOAD   = 8'(T_AS - 1);
    localparam logic [7:0] c_PWEH_LOAD = 8'(T_PWEH - 1);
    localparam logic [7:0] c_PWEL_LOAD = 8'(T_PWEL - 1);
    localparam logic [7:0] c_MAX_POLL  = 8'(MAX_POLL);

    state_t     r_state;
    logic       r_req_ready;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       r_rsp_timeout;
    logic       r_lcd_rs;
    logic       r_lcd_rw;
    logic       r_lcd_en;
    logic       r_poll;
    logic       r_dummy;
    logic [7:0] r_attempts;
    logic [7:0] r_sample;

    logic       w_accept;
    logic       w_busy;
    logic       w_poll_again;
    logic       w_tmr_load;
    logic [7:0] w_tmr_val;
    logic       w_tmr_done;

    // Request acceptance and poll-retry decision
    always_comb begin
        w_accept     = bus.req_valid && r_req_ready;
        w_busy       = st7920_busy(r_sample);
        w_poll_again = r_poll && w_busy && (r_attempts < c_MAX_POLL);
    end

    // Timer is reloaded on every transition into a timed phase
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = 8'd0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_AS_LOAD;
                end
            end
            SETUP: begin
                if (w_tmr_done) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_PWEH_LOAD;
                end
            end
            EN_HI: begin
                if (w_tmr_done) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_PWEL_LOAD;
                end
            end
            EN_LO: begin
                // A pending dummy read goes straight into a second bus cycle
                if (w_tmr_done && r_dummy) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_AS_LOAD;
                end
            end
            CHECK: begin
                if (w_poll_again) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_AS_LOAD;
                end
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    lcd_bus_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    // Bus sequencing FSM with registered pin and response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 8'd0;
            r_rsp_timeout <= 1'b0;
            r_lcd_rs      <= 1'b0;
            r_lcd_rw      <= 1'b0;
            r_lcd_en      <= 1'b0;
            r_poll        <= 1'b0;
            r_dummy       <= 1'b0;
            r_attempts    <= 8'd0;
            r_sample      <= 8'd0;
        end else begin
            // Response strobe and its qualifier are single-cycle
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_state     <= SETUP;
                        r_lcd_rw    <= 1'b1;
                        // Polling is always a status read
                        r_lcd_rs    <= bus.req_poll ? RS_STATUS : bus.req_rs;
                        r_poll      <= bus.req_poll;
                        r_attempts  <= 8'd1;
`ifdef LCD12864_DUMMY_READ_EN
                        r_dummy     <= !bus.req_poll && (bus.req_rs == RS_DATA);
`else
                        r_dummy     <= 1'b0;
`endif
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                SETUP: begin
                    if (w_tmr_done) begin
                        r_lcd_en <= 1'b1;
                        r_state  <= EN_HI;
                    end
                end

                EN_HI: begin
                    // Sample on the last E-high cycle, when read data is valid
                    if (w_tmr_done) begin
                        r_sample <= bus.lcd_dat;
                        r_lcd_en <= 1'b0;
                        r_state  <= EN_LO;
                    end
                end

                EN_LO: begin
                    if (w_tmr_done) begin
                        if (r_dummy) begin
                            r_dummy <= 1'b0;
                            r_state <= SETUP;
                        end else begin
                            r_state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (w_poll_again) begin
                        r_attempts <= r_attempts + 8'd1;
                        r_state    <= SETUP;
                    end else begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= r_sample;
                        r_rsp_timeout <= r_poll && w_busy;
                        r_lcd_rw      <= 1'b0;
                        r_lcd_rs      <= 1'b0;
                        r_state       <= RESP;
                    end
                end

                RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.lcd_rs      = r_lcd_rs;
    assign bus.lcd_rw      = r_lcd_rw;
    assign bus.lcd_en      = r_lcd_en;

endmodule : lcd12864_bus_reader
`default_nettype wire

// File: doc/lcd12864_bus_reader.md
Name: lcd12864_bus_reader

Overview:
- Read-side controller for the ST7920-based LCD12864 8-bit parallel bus. It is the counterpart of the existing write sequencer.
- Performs status reads (rs=0, rw=1), which return the busy flag and address counter, and data reads (rs=1, rw=1), which return DDRAM/CGRAM/GDRAM contents.
- Generates compliant E timing from the 50 MHz board clock.
- Sits between the host logic (valid/ready request, one-cycle response pulse) and the LCD pins. Tri-state buffering of the data bus is done at the top level.

Parameters:
- T_AS, 4, cycles from rs/rw valid to E rising (address setup).
- T_PWEH, 25, cycles E held high. Data is sampled on the last of these cycles (covers tDDR of 260 ns).
- T_PWEL, 35, cycles E held low after the falling edge, before the next bus cycle or return to IDLE (enforces tC ≥ 1.2 µs).
- MAX_POLL, 255, maximum status reads in poll mode before timeout. Range 1..255.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_rs  in  1  0=status read, 1=data read
- req_poll  in  1  1=repeat status reads until BF=0 (req_rs ignored, forced to 0)
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  8  byte read. For status reads: bit7=BF, bits6:0=AC
- rsp_timeout  out  1  qualified by rsp_valid; poll exhausted MAX_POLL attempts
- lcd_rs  out  1  LCD RS pin
- lcd_rw  out  1  LCD R/W pin; 1 during a transaction, 0 otherwise
- lcd_en  out  1  LCD E pin
- lcd_dat  in  8  LCD D7..D0 as seen through the top-level input buffer

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, lcd_rs=0, lcd_rw=0, lcd_en=0, state=IDLE, all counters=0. req_ready rises on the first cycle after rst_n is sampled high.
- Handshake:
  - A request is accepted on a cycle where req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE and drops the cycle after acceptance.
  - req_rs and req_poll are captured at acceptance.
- States:
  - IDLE → SETUP on accept. lcd_rw=1 and lcd_rs=captured rs from the first SETUP cycle.
  - SETUP (T_AS cycles, E=0) → EN_HI.
  - EN_HI (T_PWEH cycles, E=1). lcd_dat is registered on the final EN_HI cycle → EN_LO.
  - EN_LO (T_PWEL cycles, E=0; rs/rw held) → CHECK.
  - CHECK (1 cycle):
    - Normal read → RESP.
    - Poll with sampled bit7=0 → RESP.
    - Poll with bit7=1 and attempts<MAX_POLL → SETUP, attempts incremented.
    - Otherwise → RESP with timeout.
  - RESP (1 cycle): rsp_valid=1, rsp_data=last sample, rsp_timeout set as above. lcd_rw returns to 0 → IDLE.
- Latency, accept to rsp_valid: 1+T_AS+T_PWEH+T_PWEL+1+1 cycles. With default parameters this is 67 for a single read. Each extra poll attempt adds T_AS+T_PWEH+T_PWEL+1.
- rsp_data holds its value until the next RESP. rsp_timeout is meaningful only while rsp_valid=1 and is 0 otherwise.
- Attempt counter is 8 bits. It counts attempts made, including the first, and never wraps because MAX_POLL ≤ 255.
- Reset mid-transaction: on the next edge all outputs return to reset values (E drops immediately) and no response is issued.
- req_valid is ignored outside IDLE. There is no queueing.

Optional Feature:
- Macro LCD12864_DUMMY_READ_EN.
- Defined: every data read (req_rs=1, not poll) performs two complete bus cycles (SETUP/EN_HI/EN_LO twice). The first sample is discarded, matching the ST7920 rule that the first data read after an address set returns stale data. Latency increases by T_AS+T_PWEH+T_PWEL.
- Undefined: a data read is a single bus cycle and the host issues its own dummy read.
- Status reads are unaffected either way.

Decomposition:
- Package lcd12864_pkg holds:
  - state enum {IDLE, SETUP, EN_HI, EN_LO, CHECK, RESP}
  - ST7920_BF_BIT=7
  - ST7920_AC_MASK=7'h7F
  - RS_STATUS=1'b0, RS_DATA=1'b1
- One sub-module, lcd_bus_timer: a loadable 8-bit down-counter with a done flag, reused for the T_AS, T_PWEH and T_PWEL phases.

Test Plan:
- Status read, lcd_dat=8'h05, req_rs=0 → lcd_rs=0, lcd_rw=1, E high for exactly 25 cycles; rsp_valid at cycle 67 with rsp_data=8'h05, rsp_timeout=0.
- Data read, lcd_dat=8'h41, feature off → one E pulse with lcd_rs=1; rsp_data=8'h41. With feature on → two E pulses, lcd_dat changed to 8'h42 before the second pulse, rsp_data=8'h42.
- Poll, BF=1 (lcd_dat=8'h80) for 3 reads then 8'h10 → 4 E pulses; rsp_data=8'h10, rsp_timeout=0.
- Poll with BF stuck (8'hFF), MAX_POLL=4 → exactly 4 E pulses; rsp_valid with rsp_timeout=1 and rsp_data=8'hFF.
- rst_n low during EN_HI → next cycle lcd_en=0, lcd_rw=0, req_ready=0; no rsp_valid; after release a new request completes normally.
- req_valid held high continuously → back-to-back transactions. Falling edge to next rising edge of E is ≥ T_PWEL+T_AS cycles, and req_ready=0 throughout each transaction.
